// File: rtl/extend_pipe.sv
// extend_pipe: registered immediate generator for the decode stage.
//
// Decodes the immediate selected by in_immsrc from a 32-bit instruction word,
// extends it to XLEN bits and presents it, together with a sideband tag, one
// cycle after acceptance through a valid/ready handshake. A skid register
// absorbs one extra word so that in_ready depends only on local state.
//
// Parameters:
//   XLEN  - datapath width (32 or 64)
//   TAG_W - sideband tag width (>= 1)
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   flush                  - synchronous kill of all held entries
//   in_valid / in_ready    - input handshake
//   in_instr, in_immsrc    - instruction word and immediate format select
//   in_tag                 - sideband tag, passed through unchanged
//   out_valid / out_ready  - output handshake
//   out_immext, out_tag    - extended immediate and its tag
//   out_illegal            - unsupported format or out-of-range shamt
//
// Build option:
//   EXTEND_ZICSR_EN - when defined, immsrc 3'b101 yields the zero-extended
//                     CSR uimm; otherwise 3'b101 is decoded as illegal.

module extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_BAD = 3'b111
  } immsrc_e;

  // Opcode bits carry no immediate information.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  // ---------------------------------------------------------------------------
  // Decode: every format is first built as a signed 32-bit value, then
  // sign-extended to XLEN. Zero-extended formats keep bit 31 clear, so the
  // same extension step leaves them zero-extended.
  // ---------------------------------------------------------------------------
  logic signed [31:0] imm32;
  logic               dec_illegal;
  logic [XLEN-1:0]    dec_immext;

  always_comb begin
    imm32       = '0;
    dec_illegal = 1'b0;
    case (immsrc_e'(in_immsrc))
      IMM_I:  imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:  imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_J:  imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
      IMM_U:  imm32 = {in_instr[31:12], 12'b0};
`ifdef EXTEND_ZICSR_EN
      IMM_Z:  imm32 = {27'b0, in_instr[19:15]};
`endif
      IMM_SH: begin
        if (XLEN == 64) begin
          imm32 = {26'b0, in_instr[25:20]};
        end else begin
          imm32       = {27'b0, in_instr[24:20]};
          dec_illegal = in_instr[25];
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    dec_immext = XLEN'(imm32);
  end

  // ---------------------------------------------------------------------------
  // OUT + SKID storage
  // ---------------------------------------------------------------------------
  logic             skid_valid;
  logic [XLEN-1:0]  skid_immext;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_illegal;

  logic accept;
  logic out_free;

  // in_ready comes straight from the skid flop: no path from out_ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_immext   <= '0;
      out_tag      <= '0;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_immext  <= '0;
      skid_tag     <= '0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      // With SKID full in_ready is low, so no new word competes for OUT.
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_immext  <= skid_immext;
        out_tag     <= skid_tag;
        out_illegal <= skid_illegal;
        skid_valid  <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) begin
          out_immext  <= dec_immext;
          out_tag     <= in_tag;
          out_illegal <= dec_illegal;
        end
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_immext  <= dec_immext;
      skid_tag     <= in_tag;
      skid_illegal <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_extend_pipe.sv
// tb_extend_pipe: scoreboard bench for extend_pipe. Two instances (XLEN=32 and
// XLEN=64) share one stimulus stream; each has its own expected-entry queue
// and its own output monitor.

module tb_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_immsrc;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready_32, out_valid_32, out_illegal_32;
  logic [31:0] out_immext_32, out_tag_32;
  logic        in_ready_64, out_valid_64, out_illegal_64;
  logic [63:0] out_immext_64;
  logic [31:0] out_tag_64;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;

  always #5 clk = ~clk;

  extend_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_32),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid_32), .out_ready(out_ready),
    .out_immext(out_immext_32), .out_tag(out_tag_32), .out_illegal(out_illegal_32)
  );

  extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid_64), .out_ready(out_ready),
    .out_immext(out_immext_64), .out_tag(out_tag_64), .out_illegal(out_illegal_64)
  );

  // Reference model: the immediate as a mathematical integer, then truncated
  // to the datapath width. Returns {illegal, value}.
  function automatic logic [64:0] ref_imm(input logic [31:0] i, input logic [2:0] s,
                                          input int xlen);
    longint v;
    logic   ill;
    v   = 0;
    ill = 1'b0;
    case (s)
      3'd0: v = $signed(i[31:20]);
      3'd1: v = $signed({i[31:25], i[11:7]});
      3'd2: v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      3'd3: v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      3'd4: v = longint'($signed(i[31:12])) * 4096;
`ifdef EXTEND_ZICSR_EN
      3'd5: v = longint'(i[19:15]);
`else
      3'd5: ill = 1'b1;
`endif
      3'd6: begin
        if (xlen == 64) v = longint'(i[25:20]);
        else begin
          v   = longint'(i[24:20]);
          ill = i[25];
        end
      end
      default: ill = 1'b1;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {ill, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // Drive one cycle of stimulus; record expected entries for words that the
  // DUT accepts. A flush cycle discards everything held, including this word.
  task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] src,
                      input logic [31:0] tg, input logic ordy, input logic fl);
    logic [64:0] r;
    in_valid  = v;
    in_instr  = ins;
    in_immsrc = src;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    if (fl) begin
      q32.delete();
      q64.delete();
    end else if (v) begin
      if (in_ready_32) begin
        r = ref_imm(ins, src, 32);
        q32.push_back('{imm: r[63:0], tag: tg, ill: r[64]});
      end
      if (in_ready_64) begin
        r = ref_imm(ins, src, 64);
        q64.push_back('{imm: r[63:0], tag: tg, ill: r[64]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitors: a transfer happens at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid_32 && out_ready) begin
      if (q32.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon32_unexpected got tag %h required no entry", out_tag_32);
      end else begin
        e32 = q32.pop_front();
        chk("mon32_imm", {32'b0, out_immext_32}, e32.imm);
        chk("mon32_tag", {32'b0, out_tag_32}, {32'b0, e32.tag});
        chk("mon32_ill", {63'b0, out_illegal_32}, {63'b0, e32.ill});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && !flush && out_valid_64 && out_ready) begin
      if (q64.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon64_unexpected got tag %h required no entry", out_tag_64);
      end else begin
        e64 = q64.pop_front();
        chk("mon64_imm", out_immext_64, e64.imm);
        chk("mon64_tag", {32'b0, out_tag_64}, {32'b0, e64.tag});
        chk("mon64_ill", {63'b0, out_illegal_64}, {63'b0, e64.ill});
      end
    end
  end

  initial begin
    logic [31:0] ri;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF0_0093;
    in_immsrc = 3'd0;
    in_tag    = 32'h1234_5678;
    out_ready = 1'b1;

    // Reset state, with inputs active while reset is held.
    #22;
    chk("rst_out_valid", {63'b0, out_valid_32 | out_valid_64}, 64'd0);
    chk("rst_in_ready", {62'b0, in_ready_32, in_ready_64}, 64'd3);
    chk("rst_immext", out_immext_64 | {32'b0, out_immext_32}, 64'd0);
    chk("rst_tag_ill", {31'b0, out_illegal_32 | out_illegal_64, out_tag_32 | out_tag_64}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // One-cycle latency from an empty pipe.
    step(1'b1, 32'hFFF0_0093, 3'd0, 32'h0000_0100, 1'b1, 1'b0);
    chk("lat_valid", {63'b0, out_valid_32}, 64'd1);
    chk("lat_addi_imm32", {32'b0, out_immext_32}, 64'h0000_0000_FFFF_FFFF);
    chk("lat_addi_ill", {63'b0, out_illegal_32}, 64'd0);

    // Directed formats, full throughput.
    step(1'b1, 32'h8000_00B7, 3'd4, 32'h0000_0104, 1'b1, 1'b0);
    chk("u_imm64", out_immext_64, 64'hFFFF_FFFF_8000_0000);
    step(1'b1, 32'h0000_006F, 3'd3, 32'h0000_0108, 1'b1, 1'b0);
    chk("j_zero64", out_immext_64, 64'd0);
    step(1'b1, 32'h0250_0013, 3'd6, 32'h0000_010C, 1'b1, 1'b0);
    chk("sh_ill32", {63'b0, out_illegal_32}, 64'd1);
    chk("sh_imm64", out_immext_64, 64'h25);
    chk("sh_ill64", {63'b0, out_illegal_64}, 64'd0);
    step(1'b1, 32'h000F_8073, 3'd5, 32'h0000_0110, 1'b1, 1'b0);
`ifdef EXTEND_ZICSR_EN
    chk("z_imm32", {32'b0, out_immext_32}, 64'h1F);
    chk("z_ill32", {63'b0, out_illegal_32}, 64'd0);
`else
    chk("z_imm32", {32'b0, out_immext_32}, 64'd0);
    chk("z_ill32", {63'b0, out_illegal_32}, 64'd1);
`endif
    step(1'b1, 32'hFFFF_FFFF, 3'd7, 32'h0000_0114, 1'b1, 1'b0);
    chk("bad_imm64", out_immext_64, 64'd0);
    chk("bad_ill64", {63'b0, out_illegal_64}, 64'd1);
    step(1'b0, 32'd0, 3'd0, 32'd0, 1'b1, 1'b0);

    // Back-pressure: two held, in_ready low from the third cycle.
    step(1'b1, 32'h0010_0093, 3'd0, 32'h0000_0200, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0093, 3'd0, 32'h0000_0204, 1'b0, 1'b0);
    chk("bp_in_ready", {62'b0, in_ready_32, in_ready_64}, 64'd0);
    step(1'b1, 32'h0030_0093, 3'd0, 32'h0000_0208, 1'b0, 1'b0);
    step(1'b1, 32'h0030_0093, 3'd0, 32'h0000_0208, 1'b0, 1'b0);
    chk("bp_stable_tag", {32'b0, out_tag_32}, 64'h200);
    chk("bp_stable_imm", out_immext_64, 64'd1);
    step(1'b1, 32'h0030_0093, 3'd0, 32'h0000_0208, 1'b1, 1'b0);
    step(1'b1, 32'h0030_0093, 3'd0, 32'h0000_0208, 1'b1, 1'b0);
    step(1'b1, 32'h0040_0093, 3'd0, 32'h0000_020C, 1'b1, 1'b0);
    for (int unsigned k = 0; k < 4; k++) step(1'b0, 32'd0, 3'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_drained", 64'(q32.size() + q64.size()), 64'd0);

    // Flush with OUT and SKID full and a word offered.
    step(1'b1, 32'h0050_0093, 3'd0, 32'h0000_0300, 1'b0, 1'b0);
    step(1'b1, 32'h0060_0093, 3'd0, 32'h0000_0304, 1'b0, 1'b0);
    step(1'b1, 32'h0070_0093, 3'd0, 32'h0000_DEAD, 1'b0, 1'b1);
    chk("fl_out_valid", {62'b0, out_valid_32, out_valid_64}, 64'd0);
    chk("fl_in_ready", {62'b0, in_ready_32, in_ready_64}, 64'd3);
    // Flush beating a simultaneous accept.
    step(1'b1, 32'h0080_0093, 3'd0, 32'h0000_BEEF, 1'b1, 1'b1);
    chk("fl_acc_valid", {62'b0, out_valid_32, out_valid_64}, 64'd0);
    for (int unsigned k = 0; k < 3; k++) step(1'b0, 32'd0, 3'd0, 32'd0, 1'b1, 1'b0);

    // Randomised traffic.
    for (int unsigned k = 0; k < 400; k++) begin
      ri = $urandom;
      step(1'($urandom_range(0, 99) < 75), ri, 3'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) < 3));
    end
    for (int unsigned k = 0; k < 4; k++) step(1'b0, 32'd0, 3'd0, 32'd0, 1'b1, 1'b0);
    chk("rand_drained32", 64'(q32.size()), 64'd0);
    chk("rand_drained64", 64'(q64.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/extend_pipe.md
# extend_pipe

Registered, parametrised immediate generator for the in-order pipeline's decode stage. It accepts a raw 32-bit instruction word plus an immediate-format select and produces the sign- or zero-extended XLEN-wide immediate one cycle later. The immediate and a caller-defined tag travel through a valid/ready handshake, and a skid buffer keeps full throughput under back-pressure. It generalises the combinational extender to XLEN 32/64, adds shift-amount and CSR immediates, flags illegal selects, and supports flush.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- TAG_W, 32, width of the sideband tag (typically PC) carried alongside the immediate; ≥1.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill; drops all held entries.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept input this cycle.
- in_instr  in  32  raw instruction; immediate bits taken from [31:7].
- in_immsrc  in  3  format select (see Operation).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts output this cycle.
- out_immext  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the output entry.
- out_illegal  out  1  entry's immsrc was unsupported or its shamt was out of range.

## Operation
- Formats (i = in_instr); "sx" means sign-extend from i[31] to XLEN:
  - 000 I: sx {i[31:20]}
  - 001 S: sx {i[31:25], i[11:7]}
  - 010 B: sx {i[31], i[7], i[30:25], i[11:8], 0}
  - 011 J: sx {i[31], i[19:12], i[20], i[30:21], 0}
  - 100 U: sx {i[31:12], 12'b0}; for XLEN=64, bits [63:32] equal i[31].
  - 101 Z: zero-extended i[19:15] (CSR uimm). Present only with the macro; see Configuration.
  - 110 SH: XLEN=64 gives zero-extended i[25:20]. XLEN=32 gives zero-extended i[24:20], and out_illegal=1 when i[25]=1.
  - 111 and any disabled format: immext = 0, out_illegal = 1.
- Storage: one output register (OUT) plus one skid register (SKID), each holding {immext, tag, illegal, valid}.
- in_ready = !SKID.valid, driven from a register with no combinational path from out_ready.
- Input accept = in_valid && in_ready.
- Per edge, unless flush is asserted:
  - If OUT is empty or out_ready=1, OUT loads from SKID when SKID is valid, otherwise from the incoming accepted word; otherwise OUT holds.
  - An accepted word that cannot enter OUT goes into SKID.
  - SKID drains into OUT when OUT is emptied.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Flush: OUT.valid and SKID.valid clear on the next edge. A word accepted in the flush cycle is discarded. Flush overrides a simultaneous accept and a simultaneous out_ready.

## Timing
- Reset values (asynchronous, on rst_n low):
  - out_valid=0, out_immext=0, out_tag=0, out_illegal=0
  - in_ready=1
  - SKID cleared
- Latency: an accepted word is presented on out_* on the cycle after acceptance when OUT was free.
- Throughput: 1 word per cycle while out_ready=1.
- Back-pressure:
  - With out_ready=0, at most 2 entries are held.
  - in_ready drops the cycle after SKID fills.
  - in_ready rises the cycle after SKID drains.
- out_* are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-transfer: all entries are lost immediately. In-flight handshakes are void.
- Simultaneous accept and output pop with SKID empty: OUT is replaced and SKID stays empty.

## Configuration
- EXTEND_ZICSR_EN defined: immsrc 101 yields the zero-extended CSR uimm with out_illegal=0.
- EXTEND_ZICSR_EN undefined: 101 is treated as 111 (immext=0, out_illegal=1), and the Z-type logic is absent from the netlist.

## Test plan
- XLEN=32, instr 0xFFF00093 (addi -1), immsrc 000 -> after 1 cycle out_immext=0xFFFFFFFF, illegal=0.
- XLEN=64, instr 0x800000B7, immsrc 100 -> out_immext=0xFFFFFFFF80000000. J-type 0x0000006F -> out_immext=0.
- XLEN=32, shamt instr with i[25]=1, immsrc 110 -> out_illegal=1. Same instr at XLEN=64 -> out_immext=0x20 + i[24:20], illegal=0.
- Back-pressure: stream 4 words with out_ready=0 -> 2 held and in_ready=0 from the 3rd cycle. Release out_ready -> words emerge in order, none lost.
- Flush with OUT and SKID full and in_valid=1 -> next cycle out_valid=0 and in_ready=1. The flushed-cycle word never appears.
- immsrc 101, i[19:15]=0x1F -> with EXTEND_ZICSR_EN, out_immext=0x1F and illegal=0. Without the macro, 0 and illegal=1. Immsrc 111 -> 0 and illegal=1 in both builds.
